// File: rtl/roe_run_ctrl.sv
// roe_run_ctrl: run controller for the ROE core.
// Answers the host req/ack handshake and steers the PC. A run starts from
// START_ADDR after reset, or one instruction past the halt that ended the
// previous run. The core executes until the decoder flags halt. Then ack
// is raised and held until the next accepted request.
// Optional feature: define ROE_WATCHDOG_EN to end runs after MAX_CYCLES
// RUN cycles without a halt, flagged on timeout.
module roe_run_ctrl #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             halt,
    output logic             ack,
    output logic             busy,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_start,
    output logic             pc_en,
    output logic             timeout,
    output logic [CNT_W-1:0] run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_STEP = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

`ifdef ROE_WATCHDOG_EN
    localparam logic WD_EN = 1'b1;
`else
    // No watchdog: expiry can never fire, so timeout stays 0.
    localparam logic WD_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic             req_q_r;
    logic             accept_s;
    logic             wd_expire_s;
    logic             ack_r;
    logic             busy_r;
    logic             timeout_r;
    logic [CNT_W-1:0] run_cycles_r;

    // Saturating increment so a very long run never wraps the counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Request acceptance: a fresh rising edge while waiting, and watchdog expiry.
    always_comb begin
        accept_s    = req & ~req_q_r & ((state_r == S_IDLE) | (state_r == S_DONE));
        wd_expire_s = WD_EN & (state_r == S_RUN) & ~halt & (run_cycles_r == WD_LAST);
    end

    // Next-state logic plus the combinational PC strobes.
    always_comb begin
        state_next_s = state_r;
        pc_load      = 1'b0;
        pc_en        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = S_LOAD;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LOAD: begin
                pc_load      = 1'b1;
                state_next_s = S_RUN;
            end
            S_STEP: begin
                // Step over the halt that ended the previous run.
                pc_en        = 1'b1;
                state_next_s = S_RUN;
            end
            S_RUN: begin
                if (halt) begin
                    state_next_s = S_DONE;
                end else if (wd_expire_s) begin
                    state_next_s = S_DONE;
                end else begin
                    pc_en        = 1'b1;
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                if (accept_s) begin
                    state_next_s = S_STEP;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, request history and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            req_q_r      <= 1'b0;
            ack_r        <= 1'b0;
            busy_r       <= 1'b0;
            timeout_r    <= 1'b0;
            run_cycles_r <= '0;
        end else begin
            state_r <= state_next_s;
            req_q_r <= req;
            ack_r   <= (state_next_s == S_DONE);
            busy_r  <= (state_next_s == S_LOAD) | (state_next_s == S_STEP) |
                       (state_next_s == S_RUN);
            if ((state_next_s == S_LOAD) || (state_next_s == S_STEP)) begin
                run_cycles_r <= '0;
                timeout_r    <= 1'b0;
            end else if (state_r == S_RUN) begin
                run_cycles_r <= sat_inc(run_cycles_r);
                if (wd_expire_s && !halt) begin
                    timeout_r <= 1'b1;
                end
            end
        end
    end

    assign ack        = ack_r;
    assign busy       = busy_r;
    assign timeout    = timeout_r;
    assign run_cycles = run_cycles_r;
    assign pc_start   = PC_W'(START_ADDR);

endmodule

// File: tb/tb_roe_run_ctrl.sv
// Bench for roe_run_ctrl in its default build (no watchdog).
// It covers directed handshake scenarios and then randomized req/halt/reset
// traffic. Every cycle is compared against a run/handshake model.
module tb_roe_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        halt = 1'b0;
    logic        ack, busy, pc_load, pc_en, timeout;
    logic [9:0]  pc_start;
    logic [15:0] run_cycles;

    int total = 0;
    int bad   = 0;

    // Model of the handshake:
    //   setup: 0 = none, 1 = fresh start pending (PC load), 2 = resume (step over halt)
    //   running: executing instructions
    //   done_flag: a run has completed and ack is owed
    int m_setup   = 0;
    bit m_running = 1'b0;
    bit m_ack     = 1'b0;
    bit m_prev    = 1'b0;
    int m_cnt     = 0;

    always #5 clk = ~clk;

    roe_run_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .halt       (halt),
        .ack        (ack),
        .busy       (busy),
        .pc_load    (pc_load),
        .pc_start   (pc_start),
        .pc_en      (pc_en),
        .timeout    (timeout),
        .run_cycles (run_cycles)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // One clock: apply inputs, compare against model, advance model on the edge.
    task automatic cyc(input bit r, input bit h, input bit rs);
        bit edge_seen;
        req   = r;
        halt  = h;
        reset = rs;
        #1;
        chk("pc_load", pc_load, (m_setup == 1));
        chk("pc_en", pc_en, (m_setup == 2) || (m_running && !h));
        chk("ack", ack, m_ack);
        chk("busy", busy, (m_setup != 0) || m_running);
        chk("run_cycles", run_cycles, m_cnt);
        chk("timeout", timeout, 0);
        chk("pc_start", pc_start, 0);
        @(posedge clk);
        if (!rs) begin
            m_setup   = 0;
            m_running = 1'b0;
            m_ack     = 1'b0;
            m_cnt     = 0;
            m_prev    = 1'b0;
        end else begin
            edge_seen = r && !m_prev;
            if (m_setup != 0) begin
                m_setup   = 0;
                m_running = 1'b1;
            end else if (m_running) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (h) begin
                    m_running = 1'b0;
                    m_ack     = 1'b1;
                end
            end else if (edge_seen) begin
                m_setup = m_ack ? 2 : 1;
                m_ack   = 1'b0;
                m_cnt   = 0;
            end
            m_prev = r;
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset low for two edges, then release.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pc_load", pc_load, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_run_cycles", run_cycles, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            chk("idle_ack", ack, 0);
        end

        // Fresh run: one-cycle pulse, halt on the fourth RUN cycle.
        cyc(1'b1, 1'b0, 1'b1);
        chk("load_strobe", pc_load, 1);
        chk("load_busy", busy, 1);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("run1_ack", ack, 1);
        chk("run1_cycles", run_cycles, 4);
        chk("run1_busy", busy, 0);

        // Resume from DONE: STEP then halt on the first RUN cycle.
        cyc(1'b1, 1'b0, 1'b1);
        chk("step_ack_fall", ack, 0);
        chk("step_pc_en", pc_en, 1);
        chk("step_no_load", pc_load, 0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("run2_ack", ack, 1);
        chk("run2_cycles", run_cycles, 1);

        // req held high across a full run: exactly one run.
        for (int i = 0; i < 20; i++) cyc(1'b1, (i == 4), 1'b1);
        chk("held_ack", ack, 1);
        chk("held_cycles", run_cycles, 3);
        cyc(1'b0, 1'b0, 1'b1);
        chk("held_ack_after_low", ack, 1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("rerequest_ack", ack, 0);

        // Reset in the middle of a run at run_cycles = 7.
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("pre_reset_cycles", run_cycles, 7);
        cyc(1'b0, 1'b0, 1'b0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cycles", run_cycles, 0);
        chk("mid_rst_pc_en", pc_en, 0);
        // Request edge coincident with reset: reset wins.
        cyc(1'b1, 1'b0, 1'b0);
        chk("rst_wins_busy", busy, 0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("reload_after_rst", pc_load, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 60) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/roe_run_ctrl.md
# roe_run_ctrl

Run controller for the ROE core, acting as the responder side of the host `req`/`ack` program-execution handshake. It detects a host request and starts the program counter, either from the start address or by resuming past the last halt. It lets the core execute until the decoder flags a halt instruction, then raises and holds `ack` until the next request. It sits between the host/testbench interface and the PC/fetch logic in `prog`.

## Interface
- `PC_W`, 10: program counter width.
- `START_ADDR`, 0: PC value loaded on the first request after reset.
- `CNT_W`, 16: width of the run-cycle counter.
- `MAX_CYCLES`, 1000: watchdog limit in RUN cycles (used only with `ROE_WATCHDOG_EN`).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset).
- `req`  in  1  host start request; its rising edge starts a run.
- `halt`  in  1  decoder flag: the instruction at the current PC is halt.
- `ack`  out  1  run complete; held high until the next accepted request.
- `busy`  out  1  high in LOAD, STEP and RUN.
- `pc_load`  out  1  one-cycle strobe: the PC loads `pc_start`.
- `pc_start`  out  PC_W  the value `START_ADDR`.
- `pc_en`  out  1  PC advance / instruction commit enable.
- `timeout`  out  1  last run ended by the watchdog.
- `run_cycles`  out  CNT_W  number of RUN cycles in the current or last run, saturating.

## Operation
- States: IDLE, LOAD, STEP, RUN, DONE. Reset enters IDLE.
- Request detection:
  - `req_q` registers `req`.
  - An accepted request is `req & ~req_q` while in IDLE or DONE.
  - Edges in LOAD, STEP or RUN are ignored and not queued.
- Transitions:
  - IDLE → LOAD on an accepted request.
  - LOAD → RUN unconditionally. `pc_load` = 1 for this one cycle; `halt` is ignored (PC not yet valid).
  - DONE → STEP on an accepted request. `ack` falls in the same edge.
  - STEP → RUN unconditionally. `pc_en` = 1 for this one cycle to step over the halt that ended the previous run; `halt` is ignored.
  - RUN, `halt` = 0 → RUN with `pc_en` = 1 and `run_cycles` incremented.
  - RUN, `halt` = 1 → DONE. `pc_en` = 0 that cycle, so the PC stays on the halt.
  - DONE → DONE until an accepted request.
- `run_cycles`:
  - Cleared on entering LOAD or STEP.
  - Incremented on every RUN cycle, including the halt cycle.
  - Saturates at 2^CNT_W−1.
  - Holds its value in DONE.
- `timeout` is cleared on entering LOAD or STEP.
- `pc_en` and `pc_load` are combinational from state; all other outputs are registered.

## Timing
- Reset values: `ack`=0, `busy`=0, `pc_load`=0, `pc_en`=0, `timeout`=0, `run_cycles`=0, `req_q`=0.
- A `req` edge sampled at edge n puts the block in LOAD or STEP from edge n through n+1. RUN starts at edge n+1.
- Halt observed at edge m → `ack`=1 and `busy`=0 from edge m.
- Minimum request-to-ack latency is 2 cycles, when halt is present at the first RUN cycle.
- A request pulse of one clock (10 ns) is sufficient. A held-high `req` starts only one run; it must go low before it can start another.
- Reset during any state returns to IDLE with reset values on the next edge. The next run reloads `START_ADDR`.
- A simultaneous request edge and reset: reset wins.

## Configuration
- `ROE_WATCHDOG_EN` defined:
  - In RUN, if `halt`=0 and `run_cycles` == MAX_CYCLES−1, go to DONE with `timeout`=1 and `pc_en`=0 that cycle.
  - If halt and watchdog expiry occur in the same cycle, halt wins and `timeout`=0.
- `ROE_WATCHDOG_EN` undefined:
  - No watchdog; runs last until halt.
  - `timeout` is tied to 0.
  - `MAX_CYCLES` is unused.

## Test plan
- Reset low 2 cycles, then high → all outputs 0; state IDLE; `ack`=0 held for 5 idle cycles.
- `req` 1-cycle pulse; halt asserted 3 RUN cycles later → `pc_load` one cycle with `pc_start`=0. Then `pc_en` high 3 cycles, low on the halt cycle. Then `ack`=1, `run_cycles`=4, `busy`=0.
- Second `req` pulse from DONE → `ack` falls on the next edge; STEP gives `pc_en`=1 with no `pc_load`. Halt 1 cycle into RUN → `ack`=1, `run_cycles`=1.
- `req` held high for 20 cycles across a completed run → exactly one run; `ack` stays 1 until `req` falls and rises again.
- Reset asserted in RUN at `run_cycles`=7 → next edge IDLE with all outputs 0. The following request pulses `pc_load`.
- With `ROE_WATCHDOG_EN` and MAX_CYCLES=8, `halt` never set → DONE after 8 RUN cycles, `timeout`=1, `ack`=1. Repeat with halt on the 8th cycle → `timeout`=0.
